// File: rtl/turn_sequencer.sv
// Timed manoeuvre sequencer: one crossroad command in, TURN/SETTLE/COOL/DONE phases out, each phase a fixed tick count.
// Outputs are registered except req_ready, which is gated live by reset, power and enable.
module turn_sequencer #(
    parameter int TICK_DIV     = 2000000,
    parameter int TURN_TICKS   = 200,
    parameter int SETTLE_TICKS = 10,
    parameter int COOL_TICKS   = 50,
    parameter int CNT_W        = 12
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       power,
    input  logic       enable,
    input  logic       req_valid,
    input  logic [1:0] req_dir,
    output logic       req_ready,
    input  logic       abort,
    output logic [3:0] moving_state,
    output logic       busy,
    output logic       done,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        TURN   = 3'b001,
        SETTLE = 3'b010,
        COOL   = 3'b011,
        DONE   = 3'b100
    } phase_t;

    localparam logic [3:0] MS_STOP    = 4'b0000;
    localparam logic [3:0] MS_FORWARD = 4'b0001;
    localparam logic [3:0] MS_LEFT    = 4'b0100;
    localparam logic [3:0] MS_RIGHT   = 4'b1000;

    localparam logic [1:0] DIR_STRAIGHT = 2'b00;
    localparam logic [1:0] DIR_LEFT     = 2'b01;
    localparam logic [1:0] DIR_AROUND   = 2'b11;

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0]    PRESC_MAX   = PW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] TURN_LAST   = CNT_W'(TURN_TICKS - 1);
    localparam logic [CNT_W-1:0] AROUND_LAST = CNT_W'(2 * TURN_TICKS - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_TICKS - 1);
    localparam logic [CNT_W-1:0] COOL_LAST   = CNT_W'(COOL_TICKS - 1);

    phase_t           phase_q, phase_d;
    logic [1:0]       dir_q, dir_d;
    logic [PW-1:0]    presc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_last;
    logic [3:0]       ms_q, ms_d;
    logic             busy_q, done_q;
    logic             tick, phase_end, clr, kill, accept;

    assign tick      = (presc_q == PRESC_MAX);
    assign phase_end = tick && (cnt_q == cnt_last);
    assign kill      = abort || !power || !enable;
    assign req_ready = rst && (phase_q == IDLE) && power && enable;
    assign accept    = req_valid && req_ready && !abort;

    always_comb begin
        cnt_last = COOL_LAST;
        case (phase_q)
            TURN:    cnt_last = (dir_q == DIR_AROUND) ? AROUND_LAST : TURN_LAST;
            SETTLE:  cnt_last = SETTLE_LAST;
            default: cnt_last = COOL_LAST;
        endcase
    end

    always_comb begin
        phase_d = phase_q;
        dir_d   = dir_q;
        clr     = 1'b0;
        if (kill) begin
            phase_d = IDLE;
            clr     = 1'b1;
        end else begin
            case (phase_q)
                IDLE: begin
                    if (accept) begin
                        dir_d   = req_dir;
                        phase_d = (req_dir == DIR_STRAIGHT) ? COOL : TURN;
                        clr     = 1'b1;
                    end
                end
                TURN: begin
                    if (phase_end) begin
                        phase_d = SETTLE;
                        clr     = 1'b1;
                    end
                end
                SETTLE: begin
                    if (phase_end) begin
                        phase_d = COOL;
                        clr     = 1'b1;
                    end
                end
                COOL: begin
                    if (phase_end) begin
                        phase_d = DONE;
                        clr     = 1'b1;
                    end
                end
                DONE: begin
                    phase_d = IDLE;
                    clr     = 1'b1;
                end
                default: begin
                    phase_d = IDLE;
                    clr     = 1'b1;
                end
            endcase
        end
    end

    // Output values are decoded from the next phase so they land in the same register stage as the phase itself.
    always_comb begin
        ms_d = MS_STOP;
        case (phase_d)
            TURN:        ms_d = (dir_d == DIR_LEFT) ? MS_LEFT : MS_RIGHT;
            COOL, DONE:  ms_d = MS_FORWARD;
            default:     ms_d = MS_STOP;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            phase_q <= IDLE;
            dir_q   <= DIR_STRAIGHT;
            ms_q    <= MS_STOP;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            dir_q   <= dir_d;
            ms_q    <= ms_d;
            busy_q  <= (phase_d != IDLE);
            done_q  <= (phase_d == DONE);
        end
    end

    // Counters sit at zero while idle so every phase starts from a clean boundary.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else if (clr || phase_q == IDLE) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else if (tick) begin
            presc_q <= '0;
            cnt_q   <= cnt_q + 1'b1;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    assign phase        = phase_q;
    assign moving_state = ms_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Bench for turn_sequencer: reference model is a per-cycle schedule queue built from phase durations.
module tb_turn_sequencer;

    localparam int TICK_DIV     = 4;
    localparam int TURN_TICKS   = 3;
    localparam int SETTLE_TICKS = 2;
    localparam int COOL_TICKS   = 2;

    localparam logic [2:0] P_IDLE = 3'b000, P_TURN = 3'b001, P_SETTLE = 3'b010, P_COOL = 3'b011, P_DONE = 3'b100;
    localparam logic [3:0] M_STOP = 4'b0000, M_FWD = 4'b0001, M_LEFT = 4'b0100, M_RIGHT = 4'b1000;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b0;
    logic       power = 1'b1;
    logic       enable = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_dir = 2'b00;
    logic       abort = 1'b0;
    logic       req_ready;
    logic [3:0] moving_state;
    logic       busy;
    logic       done;
    logic [2:0] phase;

    turn_sequencer #(
        .TICK_DIV(TICK_DIV), .TURN_TICKS(TURN_TICKS), .SETTLE_TICKS(SETTLE_TICKS),
        .COOL_TICKS(COOL_TICKS), .CNT_W(12)
    ) dut (
        .sys_clk(sys_clk), .rst(rst), .power(power), .enable(enable),
        .req_valid(req_valid), .req_dir(req_dir), .req_ready(req_ready), .abort(abort),
        .moving_state(moving_state), .busy(busy), .done(done), .phase(phase)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [2:0] ph;
        logic [3:0] ms;
    } slot_t;

    // One queue entry per clock cycle of the manoeuvre still to come; front is the current cycle.
    slot_t q[$];
    int checks = 0;
    int errors = 0;

    function automatic void push_n(input logic [2:0] ph, input logic [3:0] ms, input int n);
        slot_t s;
        s.ph = ph;
        s.ms = ms;
        for (int i = 0; i < n; i++) q.push_back(s);
    endfunction

    function automatic void schedule(input logic [1:0] d);
        if (d != 2'b00) begin
            push_n(P_TURN, (d == 2'b01) ? M_LEFT : M_RIGHT,
                   ((d == 2'b11) ? 2 : 1) * TURN_TICKS * TICK_DIV);
            push_n(P_SETTLE, M_STOP, SETTLE_TICKS * TICK_DIV);
        end
        push_n(P_COOL, M_FWD, COOL_TICKS * TICK_DIV);
        push_n(P_DONE, M_FWD, 1);
    endfunction

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [2:0] eph;
        logic [3:0] ems;
        logic       erdy;
        eph  = (q.size() != 0) ? q[0].ph : P_IDLE;
        ems  = (q.size() != 0) ? q[0].ms : M_STOP;
        erdy = rst && (q.size() == 0) && power && enable;
        chk({tag, ".phase"}, {1'b0, phase}, {1'b0, eph});
        chk({tag, ".moving"}, moving_state, ems);
        chk({tag, ".busy"}, {3'b0, busy}, {3'b0, (q.size() != 0)});
        chk({tag, ".done"}, {3'b0, done}, {3'b0, (eph == P_DONE)});
        chk({tag, ".ready"}, {3'b0, req_ready}, {3'b0, erdy});
    endtask

    // Advance one edge: update the model with the inputs the DUT sees, then compare just after the edge.
    task automatic step(input string tag);
        @(posedge sys_clk);
        if (!rst || abort || !power || !enable) q.delete();
        else if (q.size() == 0) begin
            if (req_valid) schedule(req_dir);
        end else void'(q.pop_front());
        #1;
        check_outputs(tag);
    endtask

    task automatic issue(input string tag, input logic [1:0] d);
        req_valid = 1'b1;
        req_dir   = d;
        step(tag);
        req_valid = 1'b0;
        req_dir   = $urandom_range(3);
    endtask

    task automatic run_to_idle(input string tag);
        int n = 0;
        while (q.size() != 0 && n < 400) begin
            step(tag);
            n++;
        end
    endtask

    task automatic run_to_phase(input string tag, input logic [2:0] ph);
        int n = 0;
        while (!(q.size() != 0 && q[0].ph == ph) && n < 400) begin
            step(tag);
            n++;
        end
    endtask

    initial begin
        // Reset state, including a request offered while in reset.
        #12;
        check_outputs("reset");
        req_valid = 1'b1;
        req_dir   = 2'b01;
        step("reset_hold");
        step("reset_hold");
        req_valid = 1'b0;
        rst = 1'b1;
        step("idle");
        step("idle");

        issue("left_acc", 2'b01);
        run_to_idle("left");
        step("left_after");

        issue("around_acc", 2'b11);
        run_to_idle("around");
        issue("right_acc", 2'b10);
        run_to_idle("right");
        issue("straight_acc", 2'b00);
        run_to_idle("straight");

        // Busy rejection: a left request held during an around turn must not disturb the schedule.
        issue("busy_acc", 2'b11);
        repeat (4) step("busy_turn");
        req_valid = 1'b1;
        req_dir   = 2'b01;
        repeat (6) step("busy_rej");
        req_valid = 1'b0;
        run_to_idle("busy_rest");

        // Random commands with random request noise while busy.
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(3)) step("rnd_gap");
            issue("rnd_acc", 2'($urandom_range(3)));
            while (q.size() != 0) begin
                req_valid = 1'($urandom_range(1));
                req_dir   = 2'($urandom_range(3));
                step("rnd_busy");
            end
            req_valid = 1'b0;
            step("rnd_idle");
        end

        // Abort at cycle 5 of a turn.
        issue("abort_acc", 2'b01);
        repeat (4) step("abort_turn");
        abort = 1'b1;
        step("abort_hit");
        abort = 1'b0;
        step("abort_after");

        // Request coincident with abort is dropped.
        abort = 1'b1;
        issue("abort_req", 2'b10);
        abort = 1'b0;
        step("abort_req_after");

        // Power drop during COOL.
        issue("pwr_acc", 2'b10);
        run_to_phase("pwr_run", P_COOL);
        repeat (2) step("pwr_cool");
        power = 1'b0;
        step("pwr_drop");
        req_valid = 1'b1;
        req_dir   = 2'b01;
        repeat (3) step("pwr_off_req");
        req_valid = 1'b0;
        power = 1'b1;
        step("pwr_back");

        // Enable low: requests never accepted.
        enable = 1'b0;
        req_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req_dir = 2'($urandom_range(3));
            step("en_low");
        end
        req_valid = 1'b0;
        enable = 1'b1;
        step("en_back");

        // Random kill source at a random point of a random manoeuvre.
        for (int k = 0; k < 4; k++) begin
            issue("kill_acc", 2'($urandom_range(3)));
            repeat ($urandom_range(30)) step("kill_run");
            case ($urandom_range(2))
                0:       abort  = 1'b1;
                1:       power  = 1'b0;
                default: enable = 1'b0;
            endcase
            step("kill_hit");
            abort = 1'b0;
            power = 1'b1;
            enable = 1'b1;
            step("kill_after");
        end

        // Asynchronous reset between edges in SETTLE, then a full left turn from clean counters.
        issue("arst_acc", 2'b01);
        run_to_phase("arst_run", P_SETTLE);
        step("arst_settle");
        #2;
        rst = 1'b0;
        q.delete();
        #1;
        check_outputs("arst_now");
        @(negedge sys_clk);
        rst = 1'b1;
        step("arst_rel");
        issue("arst_left", 2'b01);
        run_to_idle("arst_left_run");
        step("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
